// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Holds the registered program counter and resolves the next fetch address
// from sequential, branch/jump, call and return requests. Call/return
// addresses are kept in a small circular return-address stack (RAS).
//
// Ports:
//   clk            core clock, rising edge
//   reset          asynchronous active-high reset
//   stall          hold PC, RAS and flags this cycle
//   branch_taken   load branch target
//   branch_rel     1: target = pc_out + branch_offset, 0: target = branch_offset
//   branch_offset  jump address or two's-complement displacement
//   call           with branch_taken: push pc_out+1 onto the RAS
//   ret            pop the RAS into the PC
//   pc_out         current fetch address (registered)
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   ras_overflow   sticky: a push hit a full RAS
//   ras_underflow  sticky: a ret hit an empty RAS
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned INST_ADDR_WIDTH = 9,
    parameter int unsigned RAS_DEPTH       = 4,
    parameter int unsigned RESET_PC        = 0,
    parameter bit          REL_BRANCH_EN   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic                       branch_rel,
    input  logic [INST_ADDR_WIDTH-1:0] branch_offset,
    input  logic                       call,
    input  logic                       ret,
    output logic [INST_ADDR_WIDTH-1:0] pc_out,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;

    logic [INST_ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [INST_ADDR_WIDTH-1:0] pc_plus1;
    logic [INST_ADDR_WIDTH-1:0] branch_target;
    logic [PTR_W-1:0]           top_ptr;
    logic                       push;

    assign pc_plus1 = pc_q + INST_ADDR_WIDTH'(1);
    // Modulo add: the two's-complement displacement wraps naturally.
    assign branch_target = (branch_rel && REL_BRANCH_EN) ? (pc_q + branch_offset)
                                                         : branch_offset;
    // The write pointer names the next free slot; the top entry sits just below.
    assign top_ptr = wr_ptr_q - PTR_W'(1);

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;

        if (!stall) begin
            if (ret) begin
                if (count_q != '0) begin
                    pc_d     = ras_q[top_ptr];
                    wr_ptr_d = top_ptr;
                    count_d  = count_q - CNT_W'(1);
                end else begin
                    pc_d        = pc_plus1;
                    underflow_d = 1'b1;
                end
            end else if (branch_taken) begin
                pc_d = branch_target;
                if (call) begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    // When full, the write pointer already addresses the
                    // oldest entry, so the push overwrites it in place.
                    if (count_q == CNT_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= INST_ADDR_WIDTH'(RESET_PC);
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // RAS storage needs no reset: entries are only read while count is nonzero.
    genvar gi;
    generate
        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    ras_q[gi] <= pc_plus1;
                end
            end
        end
    endgenerate

    assign pc_out        = pc_q;
    assign ras_empty     = (count_q == '0);
    assign ras_full      = (count_q == CNT_FULL);
    assign ras_overflow  = overflow_q;
    assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed test of pc_sequencer: sequential fetch, relative/absolute branches
// (including a second instance with relative mode disabled), call/ret through
// the RAS, overflow/underflow, request priority, stall, PC wrap and async reset.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         branch_taken;
    logic         branch_rel;
    logic [W-1:0] branch_offset;
    logic         call;
    logic         ret;

    logic [W-1:0] pc_out;
    logic         ras_empty, ras_full, ras_overflow, ras_underflow;

    logic [W-1:0] abs_pc_out;
    logic         abs_empty, abs_full, abs_overflow, abs_underflow;

    int checks_cnt;
    int errors_cnt;

    pc_sequencer #(
        .INST_ADDR_WIDTH (W),
        .RAS_DEPTH       (4),
        .RESET_PC        (0),
        .REL_BRANCH_EN   (1'b1)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_rel    (branch_rel),
        .branch_offset (branch_offset),
        .call          (call),
        .ret           (ret),
        .pc_out        (pc_out),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    pc_sequencer #(
        .INST_ADDR_WIDTH (W),
        .RAS_DEPTH       (4),
        .RESET_PC        (0),
        .REL_BRANCH_EN   (1'b0)
    ) u_dut_abs (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_rel    (branch_rel),
        .branch_offset (branch_offset),
        .call          (call),
        .ret           (ret),
        .pc_out        (abs_pc_out),
        .ras_empty     (abs_empty),
        .ras_full      (abs_full),
        .ras_overflow  (abs_overflow),
        .ras_underflow (abs_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_rel    = 1'b0;
        branch_offset = '0;
        call          = 1'b0;
        ret           = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [W-1:0] target);
        idle_inputs();
        branch_taken  = 1'b1;
        call          = 1'b1;
        branch_offset = target;
        step();
        idle_inputs();
    endtask

    task automatic do_ret();
        idle_inputs();
        ret = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic do_jump(input logic [W-1:0] target);
        idle_inputs();
        branch_taken  = 1'b1;
        branch_offset = target;
        step();
        idle_inputs();
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_pc",        32'(pc_out),        32'd0);
        check("rst_empty",     32'(ras_empty),     32'd1);
        check("rst_full",      32'(ras_full),      32'd0);
        check("rst_ovf",       32'(ras_overflow),  32'd0);
        check("rst_unf",       32'(ras_underflow), 32'd0);
        check("rst_abs_pc",    32'(abs_pc_out),    32'd0);

        // Sequential fetch 0,1,2,3
        reset = 1'b0;
        check("seq_pc0", 32'(pc_out), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), 32'(pc_out), 32'(i));
        end
        check("seq_empty", 32'(ras_empty), 32'd1);

        // Run up to pc 10
        repeat (7) step();
        check("pc_at10", 32'(pc_out), 32'd10);

        // Relative branch -4 from 10; relative-disabled copy goes absolute
        branch_taken  = 1'b1;
        branch_rel    = 1'b1;
        branch_offset = 9'h1FC;
        step();
        idle_inputs();
        check("rel_branch",     32'(pc_out),     32'd6);
        check("abs_only_branch", 32'(abs_pc_out), 32'h1FC);

        // Get to pc 5, call to 100 pushes 6
        do_jump(9'd5);
        check("jump_to5", 32'(pc_out), 32'd5);
        do_call(9'd100);
        check("call_pc",    32'(pc_out),    32'd100);
        check("call_empty", 32'(ras_empty), 32'd0);
        step();
        check("after_call_seq", 32'(pc_out), 32'd101);
        do_ret();
        check("ret_pc",    32'(pc_out),    32'd6);
        check("ret_empty", 32'(ras_empty), 32'd1);

        // Five nested calls from pc 6: pushes 7,21,41,61,81 (7 overwritten)
        do_call(9'd20);
        do_call(9'd40);
        do_call(9'd60);
        do_call(9'd80);
        check("full4_full", 32'(ras_full),     32'd1);
        check("full4_ovf",  32'(ras_overflow), 32'd0);
        do_call(9'd100);
        check("call5_pc",   32'(pc_out),       32'd100);
        check("call5_full", 32'(ras_full),     32'd1);
        check("call5_ovf",  32'(ras_overflow), 32'd1);

        do_ret();
        check("lifo_ret1", 32'(pc_out), 32'd81);
        check("lifo_notfull", 32'(ras_full), 32'd0);
        do_ret();
        check("lifo_ret2", 32'(pc_out), 32'd61);
        do_ret();
        check("lifo_ret3", 32'(pc_out), 32'd41);
        do_ret();
        check("lifo_ret4",   32'(pc_out),    32'd21);
        check("lifo_empty",  32'(ras_empty), 32'd1);
        check("lifo_no_unf", 32'(ras_underflow), 32'd0);
        do_ret();
        check("unf_pc",   32'(pc_out),        32'd22);
        check("unf_flag", 32'(ras_underflow), 32'd1);
        check("unf_empty", 32'(ras_empty),    32'd1);

        // Priority: ret beats branch_taken/call; stall beats everything
        do_call(9'd200);   // push 23
        do_call(9'd300 - 9'd0); // push 201
        check("prio_setup_pc", 32'(pc_out), 32'd300 & 32'h1FF);
        ret           = 1'b1;
        branch_taken  = 1'b1;
        call          = 1'b1;
        branch_offset = 9'd50;
        step();
        check("prio_ret_pc",    32'(pc_out),    32'd201);
        check("prio_ret_empty", 32'(ras_empty), 32'd0);
        stall = 1'b1;
        step();
        check("stall_pc",    32'(pc_out),    32'd201);
        check("stall_empty", 32'(ras_empty), 32'd0);
        idle_inputs();
        do_ret();
        check("post_stall_ret",   32'(pc_out),    32'd23);
        check("post_stall_empty", 32'(ras_empty), 32'd1);

        // Wrap from all-ones to zero, then a forward relative branch
        do_jump(9'h1FE);
        check("wrap_1fe", 32'(pc_out), 32'h1FE);
        step();
        check("wrap_1ff", 32'(pc_out), 32'h1FF);
        step();
        check("wrap_0", 32'(pc_out), 32'd0);
        branch_taken  = 1'b1;
        branch_rel    = 1'b1;
        branch_offset = 9'd5;
        step();
        idle_inputs();
        check("rel_fwd", 32'(pc_out), 32'd5);

        // call without branch_taken is ignored
        call = 1'b1;
        step();
        idle_inputs();
        check("lone_call_pc",    32'(pc_out),    32'd6);
        check("lone_call_empty", 32'(ras_empty), 32'd1);

        // Three pushes, then async reset mid-stream
        do_call(9'd10);
        do_call(9'd20);
        do_call(9'd30);
        check("pre_rst_empty", 32'(ras_empty),     32'd0);
        check("pre_rst_full",  32'(ras_full),      32'd0);
        check("sticky_ovf",    32'(ras_overflow),  32'd1);
        check("sticky_unf",    32'(ras_underflow), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc",    32'(pc_out),        32'd0);
        check("async_rst_empty", 32'(ras_empty),     32'd1);
        check("async_rst_ovf",   32'(ras_overflow),  32'd0);
        check("async_rst_unf",   32'(ras_underflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // Count must be zero: a ret now underflows
        ret = 1'b1;
        step();
        idle_inputs();
        check("rst_cnt_ret_pc",  32'(pc_out),        32'd1);
        check("rst_cnt_ret_unf", 32'(ras_underflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

    // Global timeout so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next generation of the core's branch-target path. It holds the registered program counter and resolves the next fetch address from sequential, branch/jump, call and return requests.
- Generalises the old absolute-only target computation:
  - selectable PC-relative mode;
  - parametrised address width;
  - a circular return-address stack (RAS) for call/return.
- Sits between the decode/branch-resolve stage and the instruction memory address port, one instance per core.

Parameters:
- INST_ADDR_WIDTH, 9: width of PC, offsets and RAS entries.
- RAS_DEPTH, 4: number of return-address entries; power of two, minimum 2.
- RESET_PC, 0: PC value loaded on reset.
- REL_BRANCH_EN, 1: 1 honours branch_rel; 0 forces absolute targets for every branch.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and RAS this cycle.
- branch_taken  input  1  load branch target.
- branch_rel  input  1  1 = target is pc_out + branch_offset; 0 = target is branch_offset.
- branch_offset  input  INST_ADDR_WIDTH  jump address or two's-complement displacement.
- call  input  1  with branch_taken: push pc_out+1 to the RAS.
- ret  input  1  pop the RAS into the PC.
- pc_out  output  INST_ADDR_WIDTH  current fetch address (registered).
- ras_empty  output  1  RAS holds no entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_overflow  output  1  sticky: a push hit a full RAS.
- ras_underflow  output  1  sticky: a ret hit an empty RAS.

Behaviour:
- Reset (async, any time including mid-call/ret):
  - pc_out = RESET_PC.
  - RAS pointer and count = 0.
  - ras_empty = 1; ras_full, ras_overflow and ras_underflow = 0.
- All updates occur on the rising clk edge. A new PC is visible on pc_out one cycle after the request. There is no combinational path from inputs to pc_out.
- Per-cycle priority, highest first:
  1. stall: PC, RAS and flags hold; all other requests ignored.
  2. ret: if the RAS is non-empty, pc_out takes the top entry and count decrements. If the RAS is empty, pc_out increments by 1 and ras_underflow sets. branch_taken and call are ignored in a ret cycle.
  3. branch_taken: pc_out takes the target.
     - Target = (branch_rel and REL_BRANCH_EN) ? pc_out + branch_offset : branch_offset.
     - The add is modulo 2^INST_ADDR_WIDTH, with the offset sign-interpreted; carry is discarded.
     - If call is also high, pc_out+1 (modulo) is pushed in the same cycle.
  4. Otherwise pc_out increments by 1, wrapping from all-ones to 0.
- call without branch_taken is ignored (no push).
- RAS is a circular buffer: write pointer plus a count of 0..RAS_DEPTH.
  - Push on a full RAS overwrites the oldest entry, count stays RAS_DEPTH, and ras_overflow sets.
  - Flags derive from the registered count: ras_empty when count==0, ras_full when count==RAS_DEPTH.
- Sticky flags clear only on reset.

Test Plan:
- Reset release with RESET_PC=0 and no requests for 3 cycles -> pc_out 0,1,2,3; ras_empty=1.
- pc_out=10, branch_taken=1, branch_rel=1, offset=9'h1FC (-4) -> next pc_out=6. With REL_BRANCH_EN=0 and the same stimulus -> pc_out=0x1FC.
- pc_out=5, call with absolute offset 100 -> pc_out=100, ras_empty=0. Two cycles later ret -> pc_out=7's successor stack value 6, ras_empty=1.
- 5 nested calls with RAS_DEPTH=4 -> ras_full=1 and ras_overflow=1. 4 rets return the last 4 pushed addresses in LIFO order. A 5th ret -> pc_out increments by 1 and ras_underflow=1.
- ret and branch_taken both high with a non-empty RAS -> pc_out = popped value. Same inputs with stall=1 -> pc_out and count unchanged.
- pc_out=9'h1FF with no request -> pc_out=0. reset asserted mid-stream while RAS count=3 -> immediate pc_out=RESET_PC, count=0, sticky flags cleared.
